// File: rtl/iob_data_mem.sv
`timescale 1ns/1ps
// iob_data_mem: word-addressed data memory behind an IOB slave port.
// One request is serviced at a time; after capture the slave waits WAIT_CYCLES
// cycles, then gives a one-cycle ready pulse carrying read data and an
// out-of-range error flag. Memory contents survive reset.
module iob_data_mem #(
   parameter int unsigned FE_ADDR_W   = 32,
   parameter int unsigned FE_DATA_W   = 32,
   parameter int unsigned MEM_AW      = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   iob_valid_i,
   input  logic [FE_ADDR_W-1:0]   iob_addr_i,
   input  logic [FE_DATA_W-1:0]   iob_wdata_i,
   input  logic [FE_DATA_W/8-1:0] iob_wstrb_i,
   output logic                   iob_ready_o,
   output logic [FE_DATA_W-1:0]   iob_rdata_o,
   output logic                   iob_err_o
);

   localparam int unsigned StrbW  = FE_DATA_W / 8;
   localparam int unsigned WordAW = FE_ADDR_W - 2;
   localparam int unsigned Depth  = 2 ** MEM_AW;

   // Counter preload so that RESP is entered WAIT_CYCLES edges after capture.
   localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [WordAW-1:0]    addr_q;
   logic [FE_DATA_W-1:0] wdata_q;
   logic [StrbW-1:0]     wstrb_q;
   logic [FE_DATA_W-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic [FE_DATA_W-1:0] mem_q [Depth];

   logic                 capture;
   logic                 enter_resp;
   logic [WordAW-1:0]    req_word;
   logic [FE_DATA_W-1:0] req_wdata;
   logic [StrbW-1:0]     req_wstrb;
   logic [MEM_AW-1:0]    req_idx;
   logic                 req_in_range;
   logic                 req_write;

   // Byte offset within the word has no meaning for a word-wide memory.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^iob_addr_i[1:0];

   // Select the request being completed: live inputs when RESP is entered
   // straight from IDLE (zero wait states), the captured copy otherwise.
   always_comb begin
      if (state_q == StIdle) begin
         req_word  = iob_addr_i[FE_ADDR_W-1:2];
         req_wdata = iob_wdata_i;
         req_wstrb = iob_wstrb_i;
      end else begin
         req_word  = addr_q;
         req_wdata = wdata_q;
         req_wstrb = wstrb_q;
      end
      req_idx      = req_word[MEM_AW-1:0];
      req_in_range = ((req_word >> MEM_AW) == '0);
      req_write    = |req_wstrb;
   end

   // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      capture    = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         StIdle: begin
            if (iob_valid_i) begin
               capture = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d    = StResp;
                  enter_resp = 1'b1;
                  cnt_d      = 4'd0;
               end else begin
                  state_d = StWait;
                  cnt_d   = WaitInit;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d    = StResp;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Response payload: only loaded on the edge entering RESP, zero otherwise,
   // so rdata/err drop back to 0 on the edge leaving RESP.
   always_comb begin
      rdata_d = '0;
      err_d   = 1'b0;
      if (enter_resp) begin
         err_d = ~req_in_range;
         if (req_in_range && !req_write) begin
            rdata_d = mem_q[req_idx];
         end
      end
   end

   // Control state, captured request and response registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (capture) begin
            addr_q  <= iob_addr_i[FE_ADDR_W-1:2];
            wdata_q <= iob_wdata_i;
            wstrb_q <= iob_wstrb_i;
         end
      end
   end

   // Byte-masked write on the edge entering RESP; storage is never reset.
   // reset_n gates the write because with zero wait states enter_resp can
   // follow iob_valid_i combinationally while reset is held.
   always_ff @(posedge clk) begin
      if (reset_n && enter_resp && req_in_range && req_write) begin
         for (int unsigned b = 0; b < StrbW; b++) begin
            if (req_wstrb[b]) begin
               mem_q[req_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Ready is decoded from state so reset removes it without a clock edge.
   assign iob_ready_o = (state_q == StResp);
   assign iob_rdata_o = rdata_q;
   assign iob_err_o   = err_q;

endmodule
